// File: rtl/pcie_mem_arbiter.sv
// pcie_mem_arbiter: grants the downstream memory port to one of two requesters per burst and
// routes in-order responses back through a tag FIFO. Define PCIE_ARB_RR_EN for round-robin.
module pcie_mem_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_m0_valid,
    output logic        o_m0_ready,
    input  logic [96:0] i_m0_req,
    output logic        o_m0_resp_valid,
    input  logic        i_m1_valid,
    output logic        o_m1_ready,
    input  logic [96:0] i_m1_req,
    output logic        o_m1_resp_valid,
    output logic        o_req_mem_valid,
    input  logic        i_req_mem_ready,
    output logic [96:0] o_req_mem,
    input  logic        i_resp_mem_valid,
    output logic [1:0]  o_grant,
    output logic        o_resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e           state_q;
    logic [1:0]       grant_q;
    logic [DEPTH-1:0] tags_q;
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             respErr_q;

    logic ownM0;
    logic ownM1;
    logic accept;
    logic push;
    logic pop;
    logic headTag;
    logic pickM1;

    assign ownM0 = (state_q == OWN0);
    assign ownM1 = (state_q == OWN1);

    assign o_req_mem_valid = ((ownM0 & i_m0_valid) | (ownM1 & i_m1_valid)) & ~full_q;
    assign o_req_mem       = ownM0 ? i_m0_req : (ownM1 ? i_m1_req : '0);
    assign o_m0_ready      = ownM0 & i_req_mem_ready & ~full_q;
    assign o_m1_ready      = ownM1 & i_req_mem_ready & ~full_q;

    // Bit 0 of the bundle is the last flag; only a completed burst earns a response tag.
    assign accept = o_req_mem_valid & i_req_mem_ready;
    assign push   = accept & o_req_mem[0];
    assign pop    = i_resp_mem_valid & (count_q != '0);

    assign headTag         = tags_q[rdPtr_q];
    assign o_m0_resp_valid = pop & ~headTag;
    assign o_m1_resp_valid = pop & headTag;
    assign o_grant         = grant_q;
    assign o_resp_err      = respErr_q;

`ifdef PCIE_ARB_RR_EN
    logic lastServed_q;

    assign pickM1 = i_m1_valid & (~i_m0_valid | ~lastServed_q);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            lastServed_q <= 1'b1;
        end else if ((state_q == IDLE) && (i_m0_valid | i_m1_valid)) begin
            lastServed_q <= pickM1;
        end
    end
`else
    assign pickM1 = i_m1_valid & ~i_m0_valid;
`endif

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_m0_valid | i_m1_valid) begin
                        state_q <= pickM1 ? OWN1 : OWN0;
                        grant_q <= pickM1 ? 2'b10 : 2'b01;
                    end
                end
                OWN0, OWN1: begin
                    if (push) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Full is held in a register so a same-cycle pop cannot reopen acceptance.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            tags_q    <= '0;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            respErr_q <= 1'b0;
        end else begin
            if (push) begin
                tags_q[wrPtr_q] <= ownM1;
                wrPtr_q         <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            if (i_resp_mem_valid && (count_q == '0)) begin
                respErr_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pcie_mem_arbiter.sv
// tb_pcie_mem_arbiter: random and directed traffic; a monitor checks every cycle against a
// transaction-level model of ownership, per-requester beat order and response tag order.
`timescale 1ns/1ps
module tb_pcie_mem_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic        m0Valid, m0Ready, m0RespValid;
    logic        m1Valid, m1Ready, m1RespValid;
    logic [96:0] m0Req, m1Req, reqMem;
    logic        reqMemValid, reqMemReady, respMemValid;
    logic [1:0]  grant;
    logic        respErr;

    int vectors = 0;
    int miscompares = 0;

    logic [96:0] genQ0[$];
    logic [96:0] genQ1[$];
    logic [96:0] expBeatQ0[$];
    logic [96:0] expBeatQ1[$];
    bit          pushed0, pushed1;
    int          outstanding;
    int          accepted0;

    int   owner;
    int   tagQ[$];
    logic errModel;
`ifdef PCIE_ARB_RR_EN
    int   lastServed;
`endif

    pcie_mem_arbiter #(.DEPTH(DEPTH)) dut (
        .i_clk           (clk),
        .i_nrst          (nrst),
        .i_m0_valid      (m0Valid),
        .o_m0_ready      (m0Ready),
        .i_m0_req        (m0Req),
        .o_m0_resp_valid (m0RespValid),
        .i_m1_valid      (m1Valid),
        .o_m1_ready      (m1Ready),
        .i_m1_req        (m1Req),
        .o_m1_resp_valid (m1RespValid),
        .o_req_mem_valid (reqMemValid),
        .i_req_mem_ready (reqMemReady),
        .o_req_mem       (reqMem),
        .i_resp_mem_valid(respMemValid),
        .o_grant         (grant),
        .o_resp_err      (respErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [96:0] actual,
                               input logic [96:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic failNote(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got timeout expected completion at %0t", name, $time);
    endtask

    function automatic logic [96:0] randomBeat();
        logic [127:0] raw;
        raw = {$urandom(), $urandom(), $urandom(), $urandom()};
        return raw[96:0];
    endfunction

    task automatic makeBurst(input int who, input int len);
        logic [127:0] raw;
        logic [96:0]  beat;
        for (int i = 0; i < len; i++) begin
            raw  = {$urandom(), $urandom(), $urandom(), $urandom()};
            beat = {raw[95:0], (i == len - 1)};
            if (who == 0) genQ0.push_back(beat);
            else          genQ1.push_back(beat);
        end
    endtask

    // One cycle of stimulus: observe last cycle's handshakes, then drive the next cycle.
    task automatic applyStimulus(input bit allowNew, input int validPct, input int readyPct,
                                 input int respPct, input bit forceResp);
        logic fire0, fire1, respSeen;
        @(negedge clk);
        fire0    = m0Valid & m0Ready;
        fire1    = m1Valid & m1Ready;
        respSeen = respMemValid;
        @(posedge clk);
        #1;
        if (fire0 && genQ0.size() > 0) begin
            if (genQ0[0][0]) outstanding++;
            void'(genQ0.pop_front());
            pushed0 = 1'b0;
            accepted0++;
        end
        if (fire1 && genQ1.size() > 0) begin
            if (genQ1[0][0]) outstanding++;
            void'(genQ1.pop_front());
            pushed1 = 1'b0;
        end
        if (respSeen && outstanding > 0) outstanding--;
        if (allowNew && genQ0.size() == 0 && int'($urandom_range(0, 99)) < 30)
            makeBurst(0, int'($urandom_range(1, 4)));
        if (allowNew && genQ1.size() == 0 && int'($urandom_range(0, 99)) < 30)
            makeBurst(1, int'($urandom_range(1, 4)));
        if (genQ0.size() > 0 && int'($urandom_range(0, 99)) < validPct) begin
            m0Valid = 1'b1;
            m0Req   = genQ0[0];
            if (!pushed0) begin
                expBeatQ0.push_back(genQ0[0]);
                pushed0 = 1'b1;
            end
        end else begin
            m0Valid = 1'b0;
            m0Req   = randomBeat();
        end
        if (genQ1.size() > 0 && int'($urandom_range(0, 99)) < validPct) begin
            m1Valid = 1'b1;
            m1Req   = genQ1[0];
            if (!pushed1) begin
                expBeatQ1.push_back(genQ1[0]);
                pushed1 = 1'b1;
            end
        end else begin
            m1Valid = 1'b0;
            m1Req   = randomBeat();
        end
        reqMemReady  = int'($urandom_range(0, 99)) < readyPct;
        respMemValid = forceResp || (outstanding > 0 && int'($urandom_range(0, 99)) < respPct);
    endtask

    task automatic assertReset(input int cycles);
        nrst         = 1'b0;
        m0Valid      = 1'b0;
        m1Valid      = 1'b0;
        m0Req        = '0;
        m1Req        = '0;
        reqMemReady  = 1'b0;
        respMemValid = 1'b0;
        genQ0.delete();
        genQ1.delete();
        expBeatQ0.delete();
        expBeatQ1.delete();
        pushed0     = 1'b0;
        pushed1     = 1'b0;
        outstanding = 0;
        repeat (cycles) @(posedge clk);
        #1 nrst = 1'b1;
    endtask

    task automatic drainAll();
        int guard = 0;
        while ((genQ0.size() > 0 || genQ1.size() > 0 || outstanding > 0) && guard < 1000) begin
            applyStimulus(1'b0, 100, 100, 50, 1'b0);
            guard++;
        end
        if (guard >= 1000) failNote("drain");
    endtask

    task automatic waitQueueLevel(input int who, input int level);
        int guard = 0;
        while (((who == 0) ? genQ0.size() : genQ1.size()) > level && guard < 50) begin
            applyStimulus(1'b0, 100, 100, 0, 1'b0);
            guard++;
        end
        if (guard >= 50) failNote("burstProgress");
    endtask

    // Monitor: mid-cycle, compare outputs with the model, then advance the model by one edge.
    initial begin : scoreboardMonitor
        logic        full, ownValid, accept, expR0, expR1;
        logic [1:0]  expGrant;
        logic [96:0] beat;
        int          tag, winner;
        owner    = -1;
        errModel = 1'b0;
`ifdef PCIE_ARB_RR_EN
        lastServed = 1;
`endif
        forever begin
            @(negedge clk);
            if (!nrst) begin
                checkOutput("resetGrant", 97'(grant), 97'd0);
                checkOutput("resetOutputs",
                            97'({m0Ready, m1Ready, reqMemValid, m0RespValid, m1RespValid, respErr}),
                            97'd0);
                owner    = -1;
                errModel = 1'b0;
                tagQ.delete();
`ifdef PCIE_ARB_RR_EN
                lastServed = 1;
`endif
                continue;
            end
            full     = (tagQ.size() == DEPTH);
            expGrant = (owner == 0) ? 2'b01 : ((owner == 1) ? 2'b10 : 2'b00);
            ownValid = (owner == 0) ? m0Valid : ((owner == 1) ? m1Valid : 1'b0);
            checkOutput("grant", 97'(grant), 97'(expGrant));
            checkOutput("reqValid", 97'(reqMemValid), 97'(ownValid & ~full));
            checkOutput("m0Ready", 97'(m0Ready), 97'(owner == 0 && reqMemReady && !full));
            checkOutput("m1Ready", 97'(m1Ready), 97'(owner == 1 && reqMemReady && !full));
            checkOutput("respErr", 97'(respErr), 97'(errModel));
            if (owner < 0) begin
                checkOutput("reqIdleZero", reqMem, 97'd0);
            end else if (ownValid) begin
                if ((owner == 0 ? expBeatQ0.size() : expBeatQ1.size()) == 0)
                    failNote("beatQueueEmpty");
                else
                    checkOutput("reqData", reqMem, (owner == 0) ? expBeatQ0[0] : expBeatQ1[0]);
            end
            expR0 = 1'b0;
            expR1 = 1'b0;
            if (respMemValid) begin
                if (tagQ.size() > 0) begin
                    tag   = tagQ.pop_front();
                    expR0 = (tag == 0);
                    expR1 = (tag == 1);
                end else begin
                    errModel = 1'b1;
                end
            end
            checkOutput("resp0", 97'(m0RespValid), 97'(expR0));
            checkOutput("resp1", 97'(m1RespValid), 97'(expR1));
            accept = ownValid & ~full & reqMemReady;
            if (owner >= 0 && accept) begin
                if (owner == 0 && expBeatQ0.size() > 0)      beat = expBeatQ0.pop_front();
                else if (owner == 1 && expBeatQ1.size() > 0) beat = expBeatQ1.pop_front();
                else                                         beat = '0;
                if (beat[0]) begin
                    tagQ.push_back(owner);
                    owner = -1;
                end
            end else if (owner < 0 && (m0Valid || m1Valid)) begin
                if (m0Valid && m1Valid) begin
`ifdef PCIE_ARB_RR_EN
                    winner = (lastServed == 0) ? 1 : 0;
`else
                    winner = 0;
`endif
                end else begin
                    winner = m0Valid ? 0 : 1;
                end
`ifdef PCIE_ARB_RR_EN
                lastServed = winner;
`endif
                owner = winner;
            end
        end
    end

    initial begin : mainSequence
        nrst         = 1'b0;
        m0Valid      = 1'b0;
        m1Valid      = 1'b0;
        m0Req        = '0;
        m1Req        = '0;
        reqMemReady  = 1'b0;
        respMemValid = 1'b0;
        pushed0      = 1'b0;
        pushed1      = 1'b0;
        outstanding  = 0;
        accepted0    = 0;
        @(posedge clk);
        #1;
        assertReset(2);

        repeat (2000) applyStimulus(1'b1, 80, 70, 25, 1'b0);
        drainAll();

        // Fill the tag FIFO with four completions; the fifth beat must wait for a response.
        accepted0 = 0;
        for (int i = 0; i < 5; i++) makeBurst(0, 1);
        repeat (20) applyStimulus(1'b0, 100, 100, 0, 1'b0);
        checkOutput("fullAccepted", 97'(accepted0), 97'd4);
        #1;
        checkOutput("fullStall", 97'(reqMemValid), 97'd0);
        applyStimulus(1'b0, 100, 100, 0, 1'b1);
        applyStimulus(1'b0, 100, 100, 0, 1'b0);
        checkOutput("popSameCycle", 97'(accepted0), 97'd4);
        applyStimulus(1'b0, 100, 100, 0, 1'b0);
        checkOutput("popNextCycle", 97'(accepted0), 97'd5);
        drainAll();

        // Tags m0, m1, m0 then four responses: the last one finds the FIFO empty.
        makeBurst(0, 1);
        waitQueueLevel(0, 0);
        makeBurst(1, 1);
        waitQueueLevel(1, 0);
        makeBurst(0, 1);
        waitQueueLevel(0, 0);
        repeat (4) applyStimulus(1'b0, 100, 100, 0, 1'b1);
        repeat (2) applyStimulus(1'b0, 100, 100, 0, 1'b0);
        checkOutput("respErrSticky", 97'(respErr), 97'd1);

        // Reset during the second beat of a burst with a tag still outstanding.
        assertReset(1);
        checkOutput("respErrCleared", 97'(respErr), 97'd0);
        makeBurst(0, 1);
        waitQueueLevel(0, 0);
        makeBurst(1, 3);
        waitQueueLevel(1, 2);
        assertReset(1);
        #1;
        checkOutput("midResetGrant", 97'(grant), 97'd0);
        applyStimulus(1'b0, 100, 100, 0, 1'b1);
        #1;
        checkOutput("noRespAfterReset", 97'({m0RespValid, m1RespValid}), 97'd0);
        repeat (3) applyStimulus(1'b0, 100, 100, 0, 1'b0);
        checkOutput("errAfterResetResp", 97'(respErr), 97'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pcie_mem_arbiter.md
PCIE_MEM_ARBITER -- requirements
Module: pcie_mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, which sets the number of outstanding transactions tracked for response routing (power of 2, 2..16).
REQ-002 SHALL have port i_clk  in  1  system bus clock; all state is updated on its rising edge.
REQ-003 SHALL have port i_nrst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_m0_valid  in  1  requester 0 (PCIe IO RX engine) request valid.
REQ-005 SHALL have port o_m0_ready  out  1  requester 0 beat accepted.
REQ-006 SHALL have port i_m0_req  in  97  requester 0 packed bundle {write, bytes[9:0], addr[12:0], strob[7:0], data[63:0], last}.
REQ-007 SHALL have port o_m0_resp_valid  out  1  response routed to requester 0.
REQ-008 SHALL have ports i_m1_valid, o_m1_ready, i_m1_req and o_m1_resp_valid for requester 1 (DMA), identical in direction, width and meaning to the requester 0 ports.
REQ-009 SHALL have port o_req_mem_valid  out  1  downstream request valid.
REQ-010 SHALL have port i_req_mem_ready  in  1  downstream accepts beat.
REQ-011 SHALL have port o_req_mem  out  97  downstream bundle, same packing as i_m0_req.
REQ-012 SHALL have port i_resp_mem_valid  in  1  one pulse per completed transaction, returned in order.
REQ-013 SHALL have port o_grant  out  2  registered one-hot owner (bit0=m0, bit1=m1; 00=idle).
REQ-014 SHALL have port o_resp_err  out  1  sticky flag: a response arrived with no transaction outstanding.

Function
REQ-015 SHALL implement states IDLE, OWN0 and OWN1; o_grant SHALL equal 01 in OWN0, 10 in OWN1 and 00 in IDLE.
REQ-016 In IDLE, if any i_mX_valid is 1, the block SHALL enter the OWNx state chosen by REQ-027/028 on the next edge; no beat is accepted in the arbitration cycle.
REQ-017 In OWNx, o_req_mem_valid SHALL equal i_mX_valid & ~full, o_req_mem SHALL equal i_mX_req, and o_mX_ready SHALL equal i_req_mem_ready & ~full.
REQ-018 In every state, the ready output of the requester not granted SHALL be 0, and o_req_mem SHALL be 0 in IDLE.
REQ-019 A beat SHALL be accepted when o_req_mem_valid and i_req_mem_ready are both 1; an accepted beat with last=1 SHALL end ownership, and the block SHALL return to IDLE on the next edge.
REQ-020 Grant SHALL stay locked across a multi-beat burst; while locked, the other requester SHALL NOT be granted, regardless of its valid.
REQ-021 Each accepted last beat SHALL push the owner ID (0/1) into a DEPTH-entry tag FIFO with a count of width log2(DEPTH)+1.
REQ-022 full SHALL be registered count==DEPTH; a pop in the same cycle SHALL NOT unblock acceptance that cycle.
REQ-023 i_resp_mem_valid with count>0 SHALL pop the head entry and assert the matching o_mX_resp_valid combinationally in the same cycle.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-025 i_resp_mem_valid with count==0 SHALL be dropped, SHALL assert no o_mX_resp_valid, and SHALL set o_resp_err until reset.
REQ-026 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 While i_nrst=0: state=IDLE, o_grant=00, FIFO pointers and count=0, last-served=m1, o_resp_err=0.
REQ-030 All ready, valid and resp_valid outputs SHALL be 0 during reset and in IDLE with the FIFO empty.
REQ-031 Reset asserted mid-burst SHALL abandon the burst and discard outstanding tags, with no partial response routed afterwards.

Configuration
REQ-027 With PCIE_ARB_RR_EN defined: arbitration SHALL be round-robin; on a tie the requester other than last-served wins, and last-served updates on each grant.
REQ-028 Without PCIE_ARB_RR_EN: m0 SHALL have fixed priority on a tie; last-served SHALL be unused.

Verification
REQ-032 Both valid in IDLE, RR_EN defined, after reset -> o_grant=01 next cycle; after m0's last beat the next grant is 10.
REQ-033 Same stimulus, RR_EN undefined, m0 re-requesting continuously -> o_grant=01 for every transaction; m1 starved.
REQ-034 m1 4-beat burst with m0 valid throughout -> o_grant=10 for all 4 beats, o_m0_ready=0, then 01.
REQ-035 DEPTH=4, 4 single-beat writes with no responses -> 5th beat stalled (o_req_mem_valid=0); one i_resp_mem_valid -> 5th accepted the following cycle.
REQ-036 Interleaved tags m0,m1,m0 then 3 responses -> resp_valid pulses m0, m1, m0 in order; a 4th response -> o_resp_err=1.
REQ-037 i_nrst pulsed low during the 2nd beat of a 3-beat burst -> o_grant=00, count=0, and no resp_valid routed afterwards.
